// File: rtl/pfd_tdc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pfd_tdc_pkg : shared types and helpers for the sampled PFD/TDC array     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pfd_tdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } pfd_state_t;

  // Largest magnitude the phase counter may reach; the most-negative code is excluded.
  function automatic int sat_limit(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int lock_cnt_w(input int lock_cnt);
    return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pfd_tdc_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pfd_tdc_channel : one synchronised PFD + time-to-digital counter channel |
// | Optional lock detector built when PFD_TDC_LOCK_DETECT_EN is defined.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pfd_tdc_channel
  import pfd_tdc_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             en,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             up,
  output logic             dn,
  output logic [CNT_W-1:0] err,
  output logic             err_valid,
  output logic             freq_flag,
  output logic             sat,
  output logic             lock
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(sat_limit(CNT_W));

  logic [SYNC_STAGES-1:0] r_ref_sync, r_fb_sync;
  logic                   r_ref_d1, r_fb_d1;
  logic                   w_ref_edge, w_fb_edge;

  pfd_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0] r_err, w_err_nxt;
  logic             r_err_valid, w_valid_nxt;
  logic             r_freq, w_freq_nxt;
  logic             r_sat, r_up, r_dn;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_ref_sync <= '0;
      r_fb_sync  <= '0;
      r_ref_d1   <= 1'b0;
      r_fb_d1    <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], ref_in};
      r_fb_sync  <= {r_fb_sync[SYNC_STAGES-2:0], fb_in};
      r_ref_d1   <= r_ref_sync[SYNC_STAGES-1];
      r_fb_d1    <= r_fb_sync[SYNC_STAGES-1];
    end
  end

  assign w_ref_edge = r_ref_sync[SYNC_STAGES-1] & ~r_ref_d1;
  assign w_fb_edge  = r_fb_sync[SYNC_STAGES-1] & ~r_fb_d1;
  assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_valid_nxt = 1'b0;
    w_freq_nxt  = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ref_edge && w_fb_edge) begin
            w_err_nxt   = '0;
            w_valid_nxt = 1'b1;
          end else if (w_ref_edge) begin
            w_state_nxt = LEAD_REF;
            w_cnt_nxt   = CNT_W'(1);
          end else if (w_fb_edge) begin
            w_state_nxt = LEAD_FB;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        LEAD_REF: begin
          // A coincident ref edge is swallowed: the lagging edge closes the window.
          if (w_fb_edge) begin
            w_err_nxt   = r_cnt;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_freq_nxt = w_ref_edge;
          end
        end
        LEAD_FB: begin
          if (w_ref_edge) begin
            w_err_nxt   = -r_cnt;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_freq_nxt = w_fb_edge;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_err       <= '0;
      r_err_valid <= 1'b0;
      r_freq      <= 1'b0;
      r_sat       <= 1'b0;
      r_up        <= 1'b0;
      r_dn        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
      r_err_valid <= w_valid_nxt;
      r_freq      <= w_freq_nxt;
      r_sat       <= (w_state_nxt != IDLE) && (w_cnt_nxt == c_cnt_max);
      r_up        <= (w_state_nxt == LEAD_REF);
      r_dn        <= (w_state_nxt == LEAD_FB);
    end
  end

  assign up        = r_up;
  assign dn        = r_dn;
  assign err       = r_err;
  assign err_valid = r_err_valid;
  assign freq_flag = r_freq;
  assign sat       = r_sat;

`ifdef PFD_TDC_LOCK_DETECT_EN
  localparam int                c_lk_w   = lock_cnt_w(LOCK_CNT);
  localparam logic [c_lk_w-1:0] c_lk_max = c_lk_w'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  c_tol    = CNT_W'(LOCK_TOL);

  logic [c_lk_w-1:0] r_lk_cnt;
  logic              r_lock;
  logic [CNT_W-1:0]  w_err_mag;
  logic              w_in_tol;

  assign w_err_mag = w_err_nxt[CNT_W-1] ? -w_err_nxt : w_err_nxt;
  assign w_in_tol  = (w_err_mag <= c_tol);

  // Updated from the next-state strobes so lock moves in the same cycle as err_valid.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_lk_cnt <= '0;
      r_lock   <= 1'b0;
    end else if (w_freq_nxt || (w_valid_nxt && !w_in_tol)) begin
      r_lk_cnt <= '0;
      r_lock   <= 1'b0;
    end else if (w_valid_nxt) begin
      if (r_lk_cnt >= c_lk_max - 1'b1) begin
        r_lk_cnt <= c_lk_max;
        r_lock   <= 1'b1;
      end else begin
        r_lk_cnt <= r_lk_cnt + 1'b1;
      end
    end
  end

  assign lock = r_lock;
`else
  assign lock = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pfd_tdc_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pfd_tdc_array : NCH independent sampled PFD/TDC channels, packed buses   |
// | Lock detector enabled by defining PFD_TDC_LOCK_DETECT_EN.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pfd_tdc_array
  import pfd_tdc_pkg::*;
#(
  parameter int NCH         = 1,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       ref_in,
  input  logic [NCH-1:0]       fb_in,
  output logic [NCH-1:0]       up,
  output logic [NCH-1:0]       dn,
  output logic [NCH*CNT_W-1:0] err,
  output logic [NCH-1:0]       err_valid,
  output logic [NCH-1:0]       freq_flag,
  output logic [NCH-1:0]       sat,
  output logic [NCH-1:0]       lock
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pfd_tdc_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .LOCK_TOL    (LOCK_TOL),
      .LOCK_CNT    (LOCK_CNT)
    ) u_ch (
      .clk1      (clk1),
      .rst       (rst),
      .en        (en),
      .ref_in    (ref_in[i]),
      .fb_in     (fb_in[i]),
      .up        (up[i]),
      .dn        (dn[i]),
      .err       (err[i*CNT_W +: CNT_W]),
      .err_valid (err_valid[i]),
      .freq_flag (freq_flag[i]),
      .sat       (sat[i]),
      .lock      (lock[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pfd_tdc_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pfd_tdc_array : scoreboard bench for the 4-channel PFD/TDC array      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pfd_tdc_array;

  localparam int NCH = 4, CNT_W = 8, SYNC_STAGES = 2, LOCK_TOL = 2, LOCK_CNT = 16;
  localparam int NEVER = 1000000;
`ifdef PFD_TDC_LOCK_DETECT_EN
  localparam int LK_ON = 1;
`else
  localparam int LK_ON = 0;
`endif

  logic                 clk1 = 1'b0;
  logic                 rst, en;
  logic [NCH-1:0]       ref_in, fb_in;
  logic [NCH-1:0]       up, dn, err_valid, freq_flag, sat, lock;
  logic [NCH*CNT_W-1:0] err;

  typedef struct {int ch; int err;} exp_t;
  exp_t exp_q[$];

  int n_total = 0, n_bad = 0;
  int up_cnt[NCH], dn_cnt[NCH], freq_cnt[NCH];
  int lk_model[NCH] = '{default: 0};
  int ref_t[NCH], fb_t[NCH];

  pfd_tdc_array #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES),
    .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk1(clk1), .rst(rst), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .up(up), .dn(dn), .err(err), .err_valid(err_valid),
    .freq_flag(freq_flag), .sat(sat), .lock(lock)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int err_of(input int ch);
    logic signed [CNT_W-1:0] s;
    s = err[ch*CNT_W +: CNT_W];
    return int'(s);
  endfunction

  // Output monitor: pops the scoreboard on each strobe and tracks the lock model.
  always @(posedge clk1) begin
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      int idx;
      int e;
      idx = -1;
      if (rst) lk_model[ch] = 0;
      if (up[ch]) up_cnt[ch]++;
      if (dn[ch]) dn_cnt[ch]++;
      if (up[ch] && dn[ch]) chk($sformatf("updn_excl_ch%0d", ch), 1, 0);
      if (freq_flag[ch]) begin
        freq_cnt[ch]++;
        lk_model[ch] = 0;
      end
      if (err_valid[ch]) begin
        foreach (exp_q[k]) if (idx < 0 && exp_q[k].ch == ch) idx = k;
        if (idx < 0) begin
          chk($sformatf("unexpected_valid_ch%0d", ch), 1, 0);
          lk_model[ch] = 0;
        end else begin
          e = exp_q[idx].err;
          chk($sformatf("err_ch%0d", ch), err_of(ch), e);
          if (e <= LOCK_TOL && e >= -LOCK_TOL)
            lk_model[ch] = (lk_model[ch] < LOCK_CNT) ? lk_model[ch] + 1 : LOCK_CNT;
          else
            lk_model[ch] = 0;
          exp_q.delete(idx);
        end
      end
      if (err_valid[ch] || freq_flag[ch])
        chk($sformatf("lock_strobe_ch%0d", ch), int'(lock[ch]),
            (LK_ON != 0 && lk_model[ch] >= LOCK_CNT) ? 1 : 0);
    end
  end

  task automatic clear_stats();
    for (int ch = 0; ch < NCH; ch++) begin
      up_cnt[ch] = 0; dn_cnt[ch] = 0; freq_cnt[ch] = 0;
      ref_t[ch] = NEVER; fb_t[ch] = NEVER;
    end
  endtask

  task automatic arm(input int ch, input int r, input int f);
    ref_t[ch] = r;
    fb_t[ch]  = f;
    if (r < NEVER && f < NEVER) exp_q.push_back('{ch, f - r});
  endtask

  // Two-cycle-wide pulses launched at the scheduled cycle offsets.
  task automatic run_window(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk1);
      for (int ch = 0; ch < NCH; ch++) begin
        ref_in[ch] = (c >= ref_t[ch]) && (c < ref_t[ch] + 2);
        fb_in[ch]  = (c >= fb_t[ch]) && (c < fb_t[ch] + 2);
      end
    end
    @(negedge clk1);
    ref_in = '0;
    fb_in  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      ref_t[ch] = NEVER; fb_t[ch] = NEVER;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ref_in = '0; fb_in = '0;
    clear_stats();
    repeat (3) @(negedge clk1);
    chk("rst_up", int'(up), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_strobes", int'({err_valid, freq_flag, sat, lock}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk1);

    // Reset in the middle of a measurement
    clear_stats();
    ref_t[0] = 0;
    run_window(7);
    chk("pre_rst_up0", int'(up[0]), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_up", int'(up), 0);
    chk("mid_rst_all", int'({dn, err_valid, freq_flag, sat, lock}), 0);
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    clear_stats();
    run_window(15);
    chk("post_rst_up0", up_cnt[0], 0);

    // Ref leads by 5
    clear_stats();
    arm(0, 2, 7);
    run_window(20);
    chk("lead5_up_cycles", up_cnt[0], 5);
    chk("lead5_dn_cycles", dn_cnt[0], 0);

    // Fb leads by 7, then coincident edges
    clear_stats();
    arm(1, 9, 2);
    run_window(25);
    chk("lag7_dn_cycles", dn_cnt[1], 7);
    chk("lag7_up_cycles", up_cnt[1], 0);
    chk("lag7_code", int'(err[1*CNT_W +: CNT_W]), 'hF9);
    clear_stats();
    arm(2, 3, 3);
    run_window(15);
    chk("same_updn_cycles", up_cnt[2] + dn_cnt[2], 0);

    // Frequency detect and saturation on channel 0
    clear_stats();
    for (int c = 0; c < 220; c++) begin
      @(negedge clk1);
      ref_in[0] = (c % 20) < 2;
    end
    @(negedge clk1);
    ref_in = '0;
    chk("freq_flags", freq_cnt[0], 10);
    chk("freq_up_held", int'(up[0]), 1);
    chk("sat_set", int'(sat[0]), 1);
    chk("freq_dn_cycles", dn_cnt[0], 0);
    exp_q.push_back('{0, 127});
    fb_t[0] = 0;
    run_window(10);
    chk("sat_cleared", int'(sat[0]), 0);

    // Four channels with independent leads
    clear_stats();
    arm(0, 5, 8);
    arm(1, 7, 5);
    arm(2, 5, 5);
    arm(3, 5, 15);
    run_window(30);
    chk("mc_up0", up_cnt[0], 3);
    chk("mc_dn1", dn_cnt[1], 2);
    chk("mc_updn2", up_cnt[2] + dn_cnt[2], 0);
    chk("mc_up3", up_cnt[3], 10);
    chk("mc_hold0", err_of(0), 3);
    chk("mc_hold3", err_of(3), 10);

    // Enable dropped mid-measurement
    clear_stats();
    ref_t[1] = 0;
    run_window(7);
    chk("en_pre_up1", int'(up[1]), 1);
    en = 1'b0;
    @(negedge clk1);
    chk("en_drop_up1", int'(up[1]), 0);
    run_window(10);
    en = 1'b1;
    clear_stats();
    run_window(15);
    chk("en_post_up1", up_cnt[1], 0);
    chk("en_post_freq1", freq_cnt[1], 0);

    // Lock detection: sixteen +/-1 measurements, then one +5
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) arm(0, 2, 3);
      else            arm(0, 3, 2);
      run_window(12);
      if (i == 14) chk("lock_after15", int'(lock[0]), 0);
    end
    chk("lock_after16", int'(lock[0]), LK_ON);
    arm(0, 2, 7);
    run_window(15);
    chk("lock_after_big", int'(lock[0]), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
